full_adder: RTL and testbench
=============================

# full_adder

One-bit full adder with a registered output copy and an optional bit-serial word accumulator. The combinational path computes sum/carry of `a`, `b`, `cin` with zero latency. The serial accumulator chains the carry through an internal register to add two WIDTH-bit words LSB-first, one bit per clock. It is a leaf arithmetic block, instantiated by datapaths that need either a single-bit adder cell or an area-minimal serial adder.

## Interface
Parameters:
- WIDTH, 8, serial word length in bits; legal range 1..32.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry-in; also the initial carry of a serial word.
- sum  output  1  combinational sum bit.
- cout  output  1  combinational carry-out.
- sum_r  output  1  `sum` registered on clk.
- cout_r  output  1  `cout` registered on clk.
- ser_start  input  1  begins a serial word.
- ser_valid  input  1  the current `a`/`b` bit belongs to the active serial word.
- ser_busy  output  1  a serial word is in progress.
- ser_done  output  1  one-cycle pulse when the last bit has been accumulated.
- ser_sum  output  WIDTH  accumulated serial sum; bit 0 is the first bit received.
- ser_cout  output  1  final carry of the last completed word.

## Operation
- Carry select:
  - ci = carry_q when ser_busy=1.
  - ci = cin otherwise.
- Combinational outputs:
  - sum = a ^ b ^ ci.
  - cout = (a&b) | (a&ci) | (b&ci).
- With ser_busy=0 the block is a pure full adder, and `sum`/`cout` are unaffected by reset.
- Registered outputs: sum_r <= sum and cout_r <= cout on every clock edge.
- Serial state: IDLE and ACTIVE; ser_busy = (state==ACTIVE).
- ser_start=1 (any state) at a clock edge:
  - carry_q <= cin, count <= 0, state <= ACTIVE.
  - ser_valid is ignored that cycle.
  - A start while ACTIVE aborts and restarts the word.
- In ACTIVE, at an edge with ser_valid=1 and ser_start=0:
  - ser_sum shifts right and sum enters the MSB. After WIDTH bits, the first bit is at bit 0.
  - carry_q <= cout, count <= count+1.
- Last bit (count==WIDTH-1) accepted:
  - state <= IDLE, ser_done <= 1 for one cycle, ser_cout <= cout.
- ser_valid=0 in ACTIVE: hold all state (bubbles allowed).
- ser_valid in IDLE: no effect on serial state.
- ser_sum and ser_cout hold until the next word's first accepted bit / completion.

## Timing
- sum/cout: zero-cycle combinational latency from a, b, cin (or carry_q).
- sum_r/cout_r: one cycle of latency.
- Serial word:
  - Start edge, then WIDTH accepting edges.
  - ser_done is high in the cycle after the last accepting edge.
- Reset values while rst=1 (all registers clear immediately):
  - sum_r=0, cout_r=0.
  - carry_q=0, count=0, state=IDLE.
  - ser_busy=0, ser_done=0, ser_sum=0, ser_cout=0.
- Reset mid-word aborts the word; there is no ser_done.
- First edge after rst deasserts behaves normally.

## Configuration
- FULL_ADDER_SERIAL_EN defined: the serial accumulator is built as above.
- Undefined:
  - Serial logic is removed.
  - ser_busy, ser_done, ser_sum and ser_cout are tied to 0.
  - ser_start and ser_valid are ignored.
  - ci = cin always.
- The combinational and registered paths are identical in both builds.

## Test plan
- Truth table: drive (a,b,cin) through 000..111 holding each for 100 ns, no clock. Required sum/cout: 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- Registered copy: a=1, b=1, cin=0. After one clk edge, sum_r=0 and cout_r=1; before that edge, post-reset values are 0/0.
- Serial add, WIDTH=8: start with cin=0, then feed 0xA5 and 0x5B LSB-first with ser_valid=1. Required: ser_done pulses once, ser_sum=0x00, ser_cout=1. Repeat with 0xFF+0x00 and cin=1 -> ser_sum=0x00, ser_cout=1.
- Bubbles and collision:
  - Insert ser_valid=0 cycles mid-word; the result is unchanged.
  - ser_start and ser_valid high together: the bit is ignored, and the count stays 0.
- Reset mid-word: assert rst after 3 bits. All outputs read 0 immediately, ser_busy=0, and no ser_done occurs.
- Build without FULL_ADDER_SERIAL_EN:
  - ser_* outputs stay 0 under serial stimulus.
  - Truth table still passes.

Source files
------------

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full adder with a registered output copy and an optional
//            LSB-first bit-serial word accumulator (macro FULL_ADDER_SERIAL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             cin,
   output logic             sum,
   output logic             cout,
   output logic             sum_r,
   output logic             cout_r,
   input  logic             ser_start,
   input  logic             ser_valid,
   output logic             ser_busy,
   output logic             ser_done,
   output logic [WIDTH-1:0] ser_sum,
   output logic             ser_cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic ci;
   logic sum_r_q, sum_r_d;
   logic cout_r_q, cout_r_d;

   always_comb begin
      sum  = a ^ b ^ ci;
      cout = (a & b) | (a & ci) | (b & ci);
   end

   always_comb begin
      sum_r_d  = sum;
      cout_r_d = cout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r_q  <= 1'b0;
         cout_r_q <= 1'b0;
      end else begin
         sum_r_q  <= sum_r_d;
         cout_r_q <= cout_r_d;
      end
   end

   assign sum_r  = sum_r_q;
   assign cout_r = cout_r_q;

`ifdef FULL_ADDER_SERIAL_EN

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] ser_sum_q, ser_sum_d;
   logic             ser_cout_q, ser_cout_d;
   logic             ser_done_q, ser_done_d;

   // While a word is in flight the adder cell chains its own carry.
   assign ci = (state_q == S_ACTIVE) ? carry_q : cin;

   always_comb begin
      state_d    = state_q;
      carry_d    = carry_q;
      count_d    = count_q;
      ser_sum_d  = ser_sum_q;
      ser_cout_d = ser_cout_q;
      ser_done_d = 1'b0;
      if (ser_start) begin
         // Start wins over a same-cycle valid bit and restarts an active word.
         carry_d = cin;
         count_d = '0;
         state_d = S_ACTIVE;
      end else if ((state_q == S_ACTIVE) && ser_valid) begin
         ser_sum_d            = ser_sum_q >> 1;
         ser_sum_d[WIDTH-1]   = sum;
         carry_d              = cout;
         count_d              = count_q + CW'(1);
         if (count_q == CW'(WIDTH - 1)) begin
            state_d    = S_IDLE;
            count_d    = '0;
            ser_done_d = 1'b1;
            ser_cout_d = cout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         carry_q    <= 1'b0;
         count_q    <= '0;
         ser_sum_q  <= '0;
         ser_cout_q <= 1'b0;
         ser_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         carry_q    <= carry_d;
         count_q    <= count_d;
         ser_sum_q  <= ser_sum_d;
         ser_cout_q <= ser_cout_d;
         ser_done_q <= ser_done_d;
      end
   end

   assign ser_busy = (state_q == S_ACTIVE);
   assign ser_done = ser_done_q;
   assign ser_sum  = ser_sum_q;
   assign ser_cout = ser_cout_q;

`else

   logic unused_ser;

   assign ci         = cin;
   assign unused_ser = ser_start ^ ser_valid;
   assign ser_busy   = 1'b0;
   assign ser_done   = 1'b0;
   assign ser_sum    = '0;
   assign ser_cout   = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module   : tb_full_adder
// Brief    : Directed self-checking bench for full_adder; serial expectations
//            follow whether FULL_ADDER_SERIAL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

   localparam int WIDTH = 8;

`ifdef FULL_ADDER_SERIAL_EN
   localparam bit SER = 1'b1;
`else
   localparam bit SER = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             a = 1'b0, b = 1'b0, cin = 1'b0;
   logic             ser_start = 1'b0, ser_valid = 1'b0;
   logic             sum, cout, sum_r, cout_r;
   logic             ser_busy, ser_done, ser_cout;
   logic [WIDTH-1:0] ser_sum;

   int total = 0;
   int bad   = 0;

   full_adder #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum),
      .cout     (cout),
      .sum_r    (sum_r),
      .cout_r   (cout_r),
      .ser_start(ser_start),
      .ser_valid(ser_valid),
      .ser_busy (ser_busy),
      .ser_done (ser_done),
      .ser_sum  (ser_sum),
      .ser_cout (ser_cout)
   );

   always #5 clk = ~clk;

   // Drives one serial word; bubble[i] inserts an idle cycle before bit i,
   // collide raises ser_valid with ser_start on the start cycle.
   task automatic feed(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                       input logic c, input logic [WIDTH-1:0] bubble,
                       input logic collide, output int dones,
                       output logic done_at_end);
      dones = 0;
      @(negedge clk);
      ser_start = 1'b1; ser_valid = collide; a = collide; b = collide; cin = c;
      @(posedge clk); #1;
      if (ser_done === 1'b1) dones++;
      for (int i = 0; i < WIDTH; i++) begin
         if (bubble[i]) begin
            @(negedge clk);
            ser_start = 1'b0; ser_valid = 1'b0;
            a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (ser_done === 1'b1) dones++;
         end
         @(negedge clk);
         ser_start = 1'b0; ser_valid = 1'b1; a = wa[i]; b = wb[i]; cin = ~c;
         @(posedge clk); #1;
         if (ser_done === 1'b1) dones++;
      end
      done_at_end = ser_done;
      @(negedge clk);
      ser_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
      @(posedge clk); #1;
      if (ser_done === 1'b1) dones++;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({sum_r, cout_r} !== 2'b00) begin
         bad++; $display("FAIL reset_regs: got sum_r/cout_r=%b%b want 00", sum_r, cout_r);
      end
      total++;
      if ({ser_busy, ser_done, ser_cout, ser_sum} !== '0) begin
         bad++; $display("FAIL reset_serial: got busy=%b done=%b cout=%b sum=%h want all 0",
                         ser_busy, ser_done, ser_cout, ser_sum);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_truth_table(input string tag);
      logic [7:0] exp_s, exp_c;
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;
      for (int v = 0; v < 8; v++) begin
         {a, b, cin} = 3'(v);
         #100;
         total++;
         if ({sum, cout} !== {exp_s[v], exp_c[v]}) begin
            bad++; $display("FAIL %s abc=%0d: got sum/cout=%b%b want %b%b",
                            tag, v, sum, cout, exp_s[v], exp_c[v]);
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
      #2 rst = 1'b0;
      #1;
      total++;
      if ({sum_r, cout_r} !== 2'b00) begin
         bad++; $display("FAIL reg_before_edge: got %b%b want 00", sum_r, cout_r);
      end
      @(posedge clk); #1;
      total++;
      if ({sum_r, cout_r} !== 2'b01) begin
         bad++; $display("FAIL reg_after_edge: got %b%b want 01", sum_r, cout_r);
      end
   endtask

   task automatic test_carry_select();
      @(negedge clk);
      ser_start = 1'b1; cin = 1'b1; a = 1'b0; b = 1'b0;
      @(negedge clk);
      ser_start = 1'b0; cin = 1'b0;
      #1;
      total++;
      if ({ser_busy, sum, cout} !== {SER, SER, 1'b0}) begin
         bad++; $display("FAIL carry_select: got busy/sum/cout=%b%b%b want %b%b0",
                         ser_busy, sum, cout, SER, SER);
      end
   endtask

   task automatic test_serial_add();
      int   d;
      logic de;
      feed(8'hA5, 8'h5B, 1'b0, '0, 1'b0, d, de);
      total++;
      if (d !== (SER ? 1 : 0) || de !== SER) begin
         bad++; $display("FAIL add_a5_5b_done: got pulses=%0d at_end=%b want %0d %b", d, de, SER ? 1 : 0, SER);
      end
      total++;
      if ({ser_cout, ser_sum} !== {SER, 8'h00}) begin
         bad++; $display("FAIL add_a5_5b: got cout=%b sum=%h want %b 00", ser_cout, ser_sum, SER);
      end
      feed(8'hFF, 8'h00, 1'b1, '0, 1'b0, d, de);
      total++;
      if (d !== (SER ? 1 : 0) || de !== SER) begin
         bad++; $display("FAIL add_ff_00_done: got pulses=%0d at_end=%b want %0d %b", d, de, SER ? 1 : 0, SER);
      end
      total++;
      if ({ser_cout, ser_sum} !== {SER, 8'h00}) begin
         bad++; $display("FAIL add_ff_00: got cout=%b sum=%h want %b 00", ser_cout, ser_sum, SER);
      end
   endtask

   task automatic test_reset_mid_word();
      int dones = 0;
      @(negedge clk);
      ser_start = 1'b1; cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ser_start = 1'b0; ser_valid = 1'b1; a = 1'b1; b = 1'b0;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      total++;
      if ({sum_r, cout_r, ser_busy, ser_done, ser_cout, ser_sum} !== '0) begin
         bad++; $display("FAIL reset_mid_word: got sum_r=%b cout_r=%b busy=%b done=%b cout=%b sum=%h want all 0",
                         sum_r, cout_r, ser_busy, ser_done, ser_cout, ser_sum);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ser_done === 1'b1 || ser_busy === 1'b1) dones++;
      end
      ser_valid = 1'b0;
      total++;
      if (dones !== 0) begin
         bad++; $display("FAIL reset_no_done: got %0d busy/done cycles want 0", dones);
      end
   endtask

   task automatic test_bubbles();
      int   d;
      logic de;
      feed(8'h3C, 8'h0F, 1'b1, 8'b0100_1010, 1'b0, d, de);
      total++;
      if (d !== (SER ? 1 : 0) || de !== SER) begin
         bad++; $display("FAIL bubble_done: got pulses=%0d at_end=%b want %0d %b", d, de, SER ? 1 : 0, SER);
      end
      total++;
      if ({ser_cout, ser_sum} !== {1'b0, (SER ? 8'h4C : 8'h00)}) begin
         bad++; $display("FAIL bubble_sum: got cout=%b sum=%h want 0 %h", ser_cout, ser_sum, SER ? 8'h4C : 8'h00);
      end
   endtask

   task automatic test_collision();
      int   d;
      logic de;
      feed(8'h01, 8'h01, 1'b0, '0, 1'b1, d, de);
      total++;
      if (d !== (SER ? 1 : 0) || de !== SER) begin
         bad++; $display("FAIL collision_done: got pulses=%0d at_end=%b want %0d %b", d, de, SER ? 1 : 0, SER);
      end
      total++;
      if ({ser_cout, ser_sum} !== {1'b0, (SER ? 8'h02 : 8'h00)}) begin
         bad++; $display("FAIL collision_sum: got cout=%b sum=%h want 0 %h", ser_cout, ser_sum, SER ? 8'h02 : 8'h00);
      end
   endtask

   initial begin
      test_reset();
      test_truth_table("truth_table");
      test_registered();
      test_carry_select();
      test_serial_add();
      test_reset_mid_word();
      test_bubbles();
      test_collision();
      test_truth_table("truth_table_after");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
